// File: rtl/note_guide_pkg.sv
// ============================================================================
// Module      : note_guide_pkg
// Description : Shared constants for the learning-mode note guide.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package note_guide_pkg;

    localparam logic [2:0] MODELEARN = 3'b111;

    localparam logic [1:0] PITCHL = 2'b01;
    localparam logic [1:0] PITCHM = 2'b00;
    localparam logic [1:0] PITCHH = 2'b10;

    localparam logic [4:0] NOTEMAX = 5'd21;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_SHOW    = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    typedef struct packed {
        logic [1:0] pitch;
        logic [6:0] key;
    } pattern_t;

endpackage

`default_nettype wire

// File: rtl/note_guide_debounce.sv
// ============================================================================
// Module      : key_debounce
// Description : Debounces a switch vector; strobes once per new stable value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce #(
    parameter int DEBOUNCE_CYC = 2_000_000,
    parameter int W            = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic [W-1:0] stable,
    output logic         strobe
);

    localparam int               c_CW   = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [c_CW-1:0]  c_ONE  = c_CW'(1);
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(DEBOUNCE_CYC - 1);

    logic [W-1:0]    r_samp;
    logic [W-1:0]    r_stable;
    logic [c_CW-1:0] r_cnt;
    logic            r_strobe;

    // r_cnt holds how many consecutive samples r_samp has been seen; it
    // saturates past the threshold so a held input strobes only once.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_samp   <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (din != r_samp) begin
                r_samp <= din;
                r_cnt  <= c_ONE;
            end else if (r_cnt == c_LAST) begin
                r_cnt <= r_cnt + c_ONE;
                if (r_samp != r_stable) begin
                    r_stable <= r_samp;
                    r_strobe <= 1'b1;
                end
            end else if (r_cnt < c_LAST) begin
                r_cnt <= r_cnt + c_ONE;
            end
        end
    end

    assign stable = r_stable;
    assign strobe = r_strobe;

endmodule

`default_nettype wire

// File: rtl/note_guide.sv
// ============================================================================
// Module      : note_guide
// Description : Learning mode: shows each song note on the LEDs, scores presses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_guide
    import note_guide_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 2_000_000,
    parameter int TIMEOUT_CYC  = 300_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] mode,
    input  logic [6:0] key,
    input  logic [1:0] pitch,
    input  logic       note_valid,
    input  logic [4:0] note,
    input  logic       note_last,
    output logic       note_ready,
    output logic [6:0] led,
    output logic [1:0] pitch_led,
    output logic       hit,
    output logic       miss,
    output logic [7:0] score,
    output logic       done
);

    localparam int              c_TW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TW-1:0] c_TLAST = c_TW'(TIMEOUT_CYC - 1);

    function automatic pattern_t decode(input logic [4:0] n);
        pattern_t   p;
        logic [4:0] idx;
        if (n <= 5'd7) begin
            p.pitch = PITCHL;
            idx     = n - 5'd1;
        end else if (n <= 5'd14) begin
            p.pitch = PITCHM;
            idx     = n - 5'd8;
        end else begin
            p.pitch = PITCHH;
            idx     = n - 5'd15;
        end
        p.key = 7'b1 << idx[2:0];
        return p;
    endfunction

    logic            w_active;
    logic            w_strobe;
    pattern_t        w_stable;
    logic [2:0]      r_state;
    pattern_t        r_exp;
    logic            r_last;
    logic            r_adv;
    logic [c_TW-1:0] r_tcnt;
    logic [6:0]      r_led;
    logic [1:0]      r_pled;
    logic            r_hit;
    logic            r_miss;
    logic [7:0]      r_score;
    logic            r_done;

    assign w_active = (mode == MODELEARN);

    key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .W            (9)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .clr    (!w_active),
        .din    ({pitch, key}),
        .stable (w_stable),
        .strobe (w_strobe)
    );

    always_ff @(posedge clk) begin
        if (rst || !w_active) begin
            r_state <= S_IDLE;
            r_exp   <= '0;
            r_last  <= 1'b0;
            r_adv   <= 1'b0;
            r_tcnt  <= '0;
            r_led   <= '0;
            r_pled  <= '0;
            r_hit   <= 1'b0;
            r_miss  <= 1'b0;
            r_score <= '0;
            r_done  <= 1'b0;
        end else begin
            r_hit  <= 1'b0;
            r_miss <= 1'b0;
            case (r_state)
                S_IDLE: r_state <= S_FETCH;
                S_FETCH: begin
                    if (note_valid) begin
                        r_last <= note_last;
                        // Rests and out-of-range numbers are consumed without a prompt.
                        if (note == 5'd0 || note > NOTEMAX) begin
                            if (note_last) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_exp   <= decode(note);
                            r_led   <= decode(note).key;
                            r_pled  <= decode(note).pitch;
                            r_tcnt  <= '0;
                            r_state <= S_SHOW;
                        end
                    end
                end
                S_SHOW: begin
                    if (w_strobe && w_stable.key != 7'd0) begin
                        if (w_stable == r_exp) begin
                            r_hit <= 1'b1;
                            if (r_score != 8'hFF) r_score <= r_score + 8'd1;
                            r_adv <= 1'b1;
                        end else begin
                            r_miss <= 1'b1;
                            r_adv  <= 1'b0;
                        end
                        r_led   <= '0;
                        r_pled  <= '0;
                        r_state <= S_RELEASE;
                    end else if (r_tcnt == c_TLAST) begin
                        r_miss  <= 1'b1;
                        r_adv   <= 1'b1;
                        r_led   <= '0;
                        r_pled  <= '0;
                        r_state <= S_RELEASE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (w_stable.key == 7'd0) begin
                        if (r_adv && r_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (r_adv) begin
                            r_state <= S_FETCH;
                        end else begin
                            r_tcnt  <= '0;
                            r_led   <= r_exp.key;
                            r_pled  <= r_exp.pitch;
                            r_state <= S_SHOW;
                        end
                    end
                end
                S_DONE:  r_done  <= 1'b1;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign note_ready = (r_state == S_FETCH);
    assign led        = r_led;
    assign pitch_led  = r_pled;
    assign hit        = r_hit;
    assign miss       = r_miss;
    assign score      = r_score;
    assign done       = r_done;

endmodule

`default_nettype wire
